// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl
//   Decode-and-issue stage of the vector CPU, between fetch and execute.
//   Each accepted 32-bit instruction (bit 0 = MSB) is decoded into register
//   addresses, width, ppp, immediate and control strobes, and the result is
//   held in a registered ID/EX stage. A per-register countdown scoreboard
//   blocks any instruction whose source registers are still being produced.
//
// Handshake (valid/ready):
//   fetch -> decode : the instruction transfers on a rising edge where
//                     if_valid && id_ready. id_ready is combinational and
//                     never depends on itself. If it is not accepted, fetch
//                     keeps if_valid/if_inst steady.
//   decode -> exec  : the ID/EX contents issue on a rising edge where
//                     id_valid && !ex_stall && !ex_flush. ex_flush discards
//                     the ID/EX contents instead of issuing them.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   if_valid, if_inst          instruction from fetch
//   id_ready                   instruction accepted this cycle
//   ex_stall, ex_flush         back-pressure and branch kill from execute
//   id_valid                   ID/EX holds a live instruction
//   id_rD, id_rA, id_rB        register addresses
//   id_ppp, id_WW, id_imm      ppp, width and immediate fields
//   id_wrEn ... id_R_type      control strobes (all 0 when id_valid = 0)
//   id_illegal                 the instruction in ID/EX is illegal
//   id_hazard                  if_inst is blocked by the scoreboard
module decode_issue_ctrl #(
  parameter int REG_AW  = 5,
  parameter int ALU_LAT = 2,
  parameter int LD_LAT  = 3,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [0:31]       if_inst,
  output logic              id_ready,
  input  logic              ex_stall,
  input  logic              ex_flush,
  output logic              id_valid,
  output logic [0:REG_AW-1] id_rD,
  output logic [0:REG_AW-1] id_rA,
  output logic [0:REG_AW-1] id_rB,
  output logic [0:2]        id_ppp,
  output logic [0:1]        id_WW,
  output logic [0:15]       id_imm,
  output logic              id_wrEn,
  output logic              id_memEn,
  output logic              id_memwrEn,
  output logic              id_bez,
  output logic              id_bnez,
  output logic              id_R_type,
  output logic              id_illegal,
  output logic              id_hazard
);

  localparam int NUM_REGS = 2 ** REG_AW;

  localparam logic [5:0] OP_RTYPE = 6'b101010;
  localparam logic [5:0] OP_VLD   = 6'b100000;
  localparam logic [5:0] OP_VSD   = 6'b100001;
  localparam logic [5:0] OP_VBEZ  = 6'b100010;
  localparam logic [5:0] OP_VBNEZ = 6'b100011;
  localparam logic [5:0] OP_VNOP  = 6'b111100;

  // Instruction fields, renumbered to plain descending vectors internally.
  logic [5:0]        opcode;
  logic [5:0]        func;
  logic [REG_AW-1:0] f_rd;
  logic [REG_AW-1:0] f_ra;
  logic [REG_AW-1:0] f_rb;

  assign opcode = if_inst[0:5];
  assign func   = if_inst[26:31];
  assign f_rd   = if_inst[6 +: REG_AW];
  assign f_ra   = if_inst[11 +: REG_AW];
  assign f_rb   = if_inst[16 +: REG_AW];

  // Decoded strobes and source-register usage for if_inst.
  logic dec_wr, dec_mem, dec_memwr, dec_bez, dec_bnez, dec_rtype, dec_illegal;
  logic src_a_en, src_b_en, src_d_en;
  logic unary;

  always_comb begin
    unary = (func == 6'b000100) || (func == 6'b000101) ||
            (func == 6'b001101) || (func == 6'b010000) ||
            (func == 6'b010001) || (func == 6'b010010);
  end

  always_comb begin
    dec_wr      = 1'b0;
    dec_mem     = 1'b0;
    dec_memwr   = 1'b0;
    dec_bez     = 1'b0;
    dec_bnez    = 1'b0;
    dec_rtype   = 1'b0;
    dec_illegal = 1'b0;
    src_a_en    = 1'b0;
    src_b_en    = 1'b0;
    src_d_en    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (func == 6'b000000 || (unary && f_rb != '0)) begin
          dec_illegal = 1'b1;
        end else begin
          dec_wr    = 1'b1;
          dec_rtype = 1'b1;
          src_a_en  = 1'b1;
          src_b_en  = !unary;
        end
      end
      OP_VLD: begin
        if (f_ra != '0) begin
          dec_illegal = 1'b1;
        end else begin
          dec_wr  = 1'b1;
          dec_mem = 1'b1;
        end
      end
      OP_VSD: begin
        if (f_ra != '0) begin
          dec_illegal = 1'b1;
        end else begin
          dec_mem   = 1'b1;
          dec_memwr = 1'b1;
          src_d_en  = 1'b1;
        end
      end
      OP_VBEZ: begin
        if (f_ra != '0) begin
          dec_illegal = 1'b1;
        end else begin
          dec_bez  = 1'b1;
          src_d_en = 1'b1;
        end
      end
      OP_VBNEZ: begin
        if (f_ra != '0) begin
          dec_illegal = 1'b1;
        end else begin
          dec_bnez = 1'b1;
          src_d_en = 1'b1;
        end
      end
      OP_VNOP: begin
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Scoreboard: cnt[r] != 0 means r is still being produced. The instruction
  // currently sitting in ID/EX has not loaded its counter yet, so its
  // destination is checked directly as an in-flight match.
  logic [CNT_W-1:0]  cnt [NUM_REGS];
  logic [REG_AW-1:0] cur_rd;
  logic              busy_a, busy_b, busy_d;

  assign cur_rd = id_rD;

  assign busy_a = src_a_en && (f_ra != '0) &&
                  ((cnt[f_ra] != '0) || (id_valid && id_wrEn && cur_rd == f_ra));
  assign busy_b = src_b_en && (f_rb != '0) &&
                  ((cnt[f_rb] != '0) || (id_valid && id_wrEn && cur_rd == f_rb));
  assign busy_d = src_d_en && (f_rd != '0) &&
                  ((cnt[f_rd] != '0) || (id_valid && id_wrEn && cur_rd == f_rd));

  assign id_hazard = if_valid && (busy_a || busy_b || busy_d);

  logic adv;
  logic issue;
  logic sb_load;

  assign adv      = !id_valid || !ex_stall || ex_flush;
  assign id_ready = if_valid && adv && !id_hazard && !ex_flush;
  assign issue    = id_valid && !ex_stall && !ex_flush;
  assign sb_load  = issue && id_wrEn && (cur_rd != '0);

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (reset) begin
        cnt[r] <= '0;
      end else if (sb_load && cur_rd == REG_AW'(r)) begin
        cnt[r] <= id_R_type ? CNT_W'(ALU_LAT) : CNT_W'(LD_LAT);
      end else if (!ex_stall && cnt[r] != '0) begin
        cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  // ID/EX register. Fields are held on flush/bubble; only the valid bit and
  // the strobes are cleared, which is all downstream looks at.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid   <= 1'b0;
      id_rD      <= '0;
      id_rA      <= '0;
      id_rB      <= '0;
      id_ppp     <= '0;
      id_WW      <= '0;
      id_imm     <= '0;
      id_wrEn    <= 1'b0;
      id_memEn   <= 1'b0;
      id_memwrEn <= 1'b0;
      id_bez     <= 1'b0;
      id_bnez    <= 1'b0;
      id_R_type  <= 1'b0;
      id_illegal <= 1'b0;
    end else if (ex_flush || (adv && !id_ready)) begin
      id_valid   <= 1'b0;
      id_wrEn    <= 1'b0;
      id_memEn   <= 1'b0;
      id_memwrEn <= 1'b0;
      id_bez     <= 1'b0;
      id_bnez    <= 1'b0;
      id_R_type  <= 1'b0;
      id_illegal <= 1'b0;
    end else if (id_ready) begin
      id_valid   <= 1'b1;
      id_rD      <= if_inst[6 +: REG_AW];
      id_rA      <= if_inst[11 +: REG_AW];
      id_rB      <= if_inst[16 +: REG_AW];
      id_ppp     <= if_inst[21:23];
      id_WW      <= if_inst[24:25];
      id_imm     <= if_inst[16:31];
      id_wrEn    <= dec_wr;
      id_memEn   <= dec_mem;
      id_memwrEn <= dec_memwr;
      id_bez     <= dec_bez;
      id_bnez    <= dec_bnez;
      id_R_type  <= dec_rtype;
      id_illegal <= dec_illegal;
    end
    // !adv: hold everything
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed testbench for decode_issue_ctrl. Inputs are driven and outputs
// sampled around the falling edge; the design acts on the rising edge.
module tb_decode_issue_ctrl;

  localparam int ALU_LAT = 2;
  localparam int LD_LAT  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [0:31] if_inst;
  logic        id_ready;
  logic        ex_stall;
  logic        ex_flush;
  logic        id_valid;
  logic [0:4]  id_rD, id_rA, id_rB;
  logic [0:2]  id_ppp;
  logic [0:1]  id_WW;
  logic [0:15] id_imm;
  logic        id_wrEn, id_memEn, id_memwrEn, id_bez, id_bnez, id_R_type;
  logic        id_illegal, id_hazard;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_issue_ctrl #(.REG_AW(5), .ALU_LAT(ALU_LAT), .LD_LAT(LD_LAT), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst),
    .id_ready(id_ready), .ex_stall(ex_stall), .ex_flush(ex_flush),
    .id_valid(id_valid), .id_rD(id_rD), .id_rA(id_rA), .id_rB(id_rB),
    .id_ppp(id_ppp), .id_WW(id_WW), .id_imm(id_imm), .id_wrEn(id_wrEn),
    .id_memEn(id_memEn), .id_memwrEn(id_memwrEn), .id_bez(id_bez),
    .id_bnez(id_bnez), .id_R_type(id_R_type), .id_illegal(id_illegal),
    .id_hazard(id_hazard)
  );

  localparam logic [0:5] OP_RTYPE = 6'b101010;
  localparam logic [0:5] OP_VLD   = 6'b100000;
  localparam logic [0:5] OP_VSD   = 6'b100001;
  localparam logic [0:5] OP_VBEZ  = 6'b100010;
  localparam logic [0:5] OP_VBNEZ = 6'b100011;
  localparam logic [0:5] OP_VNOP  = 6'b111100;

  // ppp is always 101 and WW always 10 in these vectors.
  function automatic logic [0:31] mk(input logic [0:5] op, input logic [0:4] rd,
                                     input logic [0:4] ra, input logic [0:4] rb,
                                     input logic [0:5] fn);
    return {op, rd, ra, rb, 3'b101, 2'b10, fn};
  endfunction

  // ---------------- clock / reset helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [0:31] inst);
    if_valid = v;
    if_inst  = inst;
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 32'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    ex_stall = 1'b0;
    ex_flush = 1'b0;
    drive(1'b0, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
    total++; if ({id_wrEn, id_memEn, id_memwrEn, id_bez, id_bnez, id_R_type, id_illegal} !== 7'b0) begin
      bad++; $display("FAIL reset_strobes got=%b exp=0", {id_wrEn, id_memEn, id_memwrEn, id_bez, id_bnez, id_R_type, id_illegal});
    end
    total++; if ({id_rD, id_rA, id_rB, id_imm} !== 31'b0) begin bad++; $display("FAIL reset_fields got=%h exp=0", {id_rD, id_rA, id_rB, id_imm}); end
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", id_ready); end
  endtask

  task automatic test_rtype();
    drive(1'b1, mk(OP_RTYPE, 5'd3, 5'd1, 5'd2, 6'b000001));
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL rtype_ready got=%b exp=1", id_ready); end
    tick();
    drive(1'b0, 32'd0);
    total++; if ({id_valid, id_wrEn, id_R_type, id_illegal} !== 4'b1110) begin
      bad++; $display("FAIL rtype_strobes got=%b exp=1110", {id_valid, id_wrEn, id_R_type, id_illegal});
    end
    total++; if ({id_rD, id_rA, id_rB} !== {5'd3, 5'd1, 5'd2}) begin
      bad++; $display("FAIL rtype_regs got=%0d/%0d/%0d exp=3/1/2", id_rD, id_rA, id_rB);
    end
    total++; if ({id_ppp, id_WW, id_imm} !== {3'b101, 2'b10, 16'h1581}) begin
      bad++; $display("FAIL rtype_fields got=%b/%b/%h exp=101/10/1581", id_ppp, id_WW, id_imm);
    end
    tick();
    total++; if (dut.cnt[3] !== 2'd2) begin bad++; $display("FAIL rtype_cnt3 got=%0d exp=2", dut.cnt[3]); end
    tick();
    total++; if (dut.cnt[3] !== 2'd1) begin bad++; $display("FAIL rtype_cnt3_dec got=%0d exp=1", dut.cnt[3]); end
    idle(4);
  endtask

  // Producer writes rd; consumer reads it. The producer issues on the edge
  // after it is accepted, loading cnt[rd] = lat; the consumer becomes ready
  // exactly lat edges after that issue edge, with bubbles in ID/EX meanwhile.
  task automatic test_raw(input string nm, input logic [0:31] prod, input logic [0:31] cons,
                          input logic [0:4] rd, input logic [0:4] cons_rd, input int lat);
    int k;
    int bubbles_live;
    drive(1'b1, prod);
    tick();
    drive(1'b1, cons);
    total++; if ({id_hazard, id_ready} !== 2'b10) begin
      bad++; $display("FAIL %s_inflight hazard/ready got=%b exp=10", nm, {id_hazard, id_ready});
    end
    tick();
    total++; if (dut.cnt[rd] !== 2'(lat)) begin bad++; $display("FAIL %s_cnt_load got=%0d exp=%0d", nm, dut.cnt[rd], lat); end
    total++; if ({id_valid, id_hazard} !== 2'b01) begin
      bad++; $display("FAIL %s_bubble valid/hazard got=%b exp=01", nm, {id_valid, id_hazard});
    end
    k = 0;
    bubbles_live = 0;
    while (id_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
      if (id_valid !== 1'b0) bubbles_live++;
    end
    total++; if (k !== lat) begin bad++; $display("FAIL %s_issue_delay got=%0d exp=%0d", nm, k, lat); end
    total++; if (bubbles_live !== 0) begin bad++; $display("FAIL %s_bubbles live_cycles=%0d exp=0", nm, bubbles_live); end
    tick();
    drive(1'b0, 32'd0);
    total++; if ({id_valid, id_rD} !== {1'b1, cons_rd}) begin
      bad++; $display("FAIL %s_consumer valid/rD got=%b/%0d exp=1/%0d", nm, id_valid, id_rD, cons_rd);
    end
    idle(6);
  endtask

  task automatic test_decode();
    logic [0:31] vi [10];
    logic [6:0]  ve [10];   // {wr, mem, memwr, bez, bnez, rtype, illegal}
    vi[0] = mk(OP_RTYPE, 5'd10, 5'd1, 5'd7, 6'b000100); ve[0] = 7'b0000001;
    vi[1] = mk(OP_RTYPE, 5'd10, 5'd1, 5'd0, 6'b000100); ve[1] = 7'b1000010;
    vi[2] = mk(OP_VNOP,  5'd0,  5'd0, 5'd0, 6'b000000); ve[2] = 7'b0000000;
    vi[3] = mk(6'b000000, 5'd1, 5'd2, 5'd3, 6'b000001); ve[3] = 7'b0000001;
    vi[4] = mk(OP_RTYPE, 5'd10, 5'd1, 5'd2, 6'b000000); ve[4] = 7'b0000001;
    vi[5] = mk(OP_VSD,   5'd4,  5'd0, 5'd0, 6'b000000); ve[5] = 7'b0110000;
    vi[6] = mk(OP_VBEZ,  5'd4,  5'd1, 5'd0, 6'b000000); ve[6] = 7'b0000001;
    vi[7] = mk(OP_VBNEZ, 5'd4,  5'd0, 5'd0, 6'b000000); ve[7] = 7'b0000100;
    vi[8] = mk(OP_VLD,   5'd11, 5'd3, 5'd0, 6'b000000); ve[8] = 7'b0000001;
    vi[9] = mk(OP_VLD,   5'd11, 5'd0, 5'd0, 6'b000000); ve[9] = 7'b1100000;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vi[i]);
      tick();
      drive(1'b0, 32'd0);
      total++;
      if ({id_valid, id_wrEn, id_memEn, id_memwrEn, id_bez, id_bnez, id_R_type, id_illegal} !== {1'b1, ve[i]}) begin
        bad++;
        $display("FAIL decode_vec%0d got=%b exp=%b", i,
                 {id_valid, id_wrEn, id_memEn, id_memwrEn, id_bez, id_bnez, id_R_type, id_illegal}, {1'b1, ve[i]});
      end
      idle(4);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, mk(OP_RTYPE, 5'd15, 5'd1, 5'd2, 6'b000001));
    tick();
    drive(1'b1, mk(OP_RTYPE, 5'd13, 5'd1, 5'd2, 6'b000001));
    tick();                                   // r15 producer issued, r13 in ID/EX
    ex_stall = 1'b1;
    drive(1'b1, mk(OP_RTYPE, 5'd14, 5'd1, 5'd2, 6'b000001));
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", id_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({id_valid, id_rD, id_wrEn, id_ready} !== {1'b1, 5'd13, 1'b1, 1'b0}) begin
        bad++; $display("FAIL stall_hold%0d valid/rD/wr/ready got=%b/%0d/%b/%b exp=1/13/1/0", i, id_valid, id_rD, id_wrEn, id_ready);
      end
      total++; if (dut.cnt[15] !== 2'd2) begin bad++; $display("FAIL stall_freeze%0d cnt15 got=%0d exp=2", i, dut.cnt[15]); end
    end
    ex_stall = 1'b0;
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b exp=1", id_ready); end
    tick();
    drive(1'b0, 32'd0);
    total++; if ({id_valid, id_rD} !== {1'b1, 5'd14}) begin
      bad++; $display("FAIL stall_next valid/rD got=%b/%0d exp=1/14", id_valid, id_rD);
    end
    total++; if ({dut.cnt[13], dut.cnt[15]} !== {2'd2, 2'd1}) begin
      bad++; $display("FAIL stall_counters cnt13/cnt15 got=%0d/%0d exp=2/1", dut.cnt[13], dut.cnt[15]);
    end
    tick();
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL stall_no_dup valid got=%b exp=0", id_valid); end
    idle(4);
  endtask

  task automatic test_flush();
    drive(1'b1, mk(OP_VLD, 5'd6, 5'd0, 5'd0, 6'b000000));
    tick();
    total++; if ({id_valid, id_rD, id_memEn} !== {1'b1, 5'd6, 1'b1}) begin
      bad++; $display("FAIL flush_load valid/rD/mem got=%b/%0d/%b exp=1/6/1", id_valid, id_rD, id_memEn);
    end
    ex_stall = 1'b1;
    ex_flush = 1'b1;
    drive(1'b1, mk(OP_RTYPE, 5'd16, 5'd6, 5'd0, 6'b000001));
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", id_ready); end
    tick();
    ex_stall = 1'b0;
    ex_flush = 1'b0;
    #1;
    total++; if ({id_valid, id_wrEn, id_memEn} !== 3'b000) begin
      bad++; $display("FAIL flush_kill valid/wr/mem got=%b exp=000", {id_valid, id_wrEn, id_memEn});
    end
    total++; if (dut.cnt[6] !== 2'd0) begin bad++; $display("FAIL flush_cnt6 got=%0d exp=0", dut.cnt[6]); end
    total++; if ({id_hazard, id_ready} !== 2'b01) begin
      bad++; $display("FAIL flush_reader hazard/ready got=%b exp=01", {id_hazard, id_ready});
    end
    tick();
    drive(1'b0, 32'd0);
    total++; if ({id_valid, id_rA} !== {1'b1, 5'd6}) begin
      bad++; $display("FAIL flush_reader_issue valid/rA got=%b/%0d exp=1/6", id_valid, id_rA);
    end
    idle(4);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, mk(OP_VLD, 5'd7, 5'd0, 5'd0, 6'b000000));
    tick();
    drive(1'b0, 32'd0);
    tick();                                   // load issued, cnt[7] = LD_LAT
    ex_stall = 1'b1;
    drive(1'b1, mk(OP_RTYPE, 5'd17, 5'd7, 5'd0, 6'b000001));
    total++; if (id_hazard !== 1'b1) begin bad++; $display("FAIL rstmid_hazard got=%b exp=1", id_hazard); end
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    ex_stall = 1'b0;
    #1;
    total++; if ({id_valid, dut.cnt[7]} !== 3'b000) begin
      bad++; $display("FAIL rstmid_clear valid/cnt7 got=%b/%0d exp=0/0", id_valid, dut.cnt[7]);
    end
    total++; if ({id_hazard, id_ready} !== 2'b01) begin
      bad++; $display("FAIL rstmid_reader hazard/ready got=%b exp=01", {id_hazard, id_ready});
    end
    tick();
    drive(1'b0, 32'd0);
    total++; if ({id_valid, id_rD} !== {1'b1, 5'd17}) begin
      bad++; $display("FAIL rstmid_issue valid/rD got=%b/%0d exp=1/17", id_valid, id_rD);
    end
    idle(4);
  endtask

  initial begin
    reset    = 1'b1;
    if_valid = 1'b0;
    if_inst  = 32'd0;
    ex_stall = 1'b0;
    ex_flush = 1'b0;
    @(negedge clk);
    test_reset();
    test_rtype();
    test_raw("vld_raw", mk(OP_VLD, 5'd5, 5'd0, 5'd0, 6'b000000),
             mk(OP_RTYPE, 5'd9, 5'd5, 5'd0, 6'b000001), 5'd5, 5'd9, LD_LAT);
    test_raw("alu_raw", mk(OP_RTYPE, 5'd12, 5'd1, 5'd2, 6'b000001),
             mk(OP_RTYPE, 5'd9, 5'd12, 5'd0, 6'b000001), 5'd12, 5'd9, ALU_LAT);
    test_raw("bnez_raw", mk(OP_RTYPE, 5'd12, 5'd1, 5'd2, 6'b000001),
             mk(OP_VBNEZ, 5'd12, 5'd0, 5'd0, 6'b000000), 5'd12, 5'd12, ALU_LAT);
    test_decode();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- Registered, parametrised decode-and-issue stage for the vector CPU, between fetch and execute.
- Decodes the 32-bit instruction (bit 0 = MSB) into register addresses, width, ppp, immediate and control strobes, and holds them in an ID/EX output register.
- Adds VLD write-back, illegal-instruction flagging, downstream stall, branch flush, and a per-register countdown scoreboard that interlocks RAW hazards.

Parameters:
- REG_AW, 5, register address width; NUM_REGS = 2**REG_AW; register 0 is never busy.
- ALU_LAT, 2, cycles from issue until an R-type result may be read.
- LD_LAT, 3, cycles from issue until a VLD result may be read.
- CNT_W, 2, scoreboard counter width; must hold max(ALU_LAT, LD_LAT).

Ports:
- clk  in  1  clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_valid  in  1  if_inst is valid this cycle.
- if_inst  in  [0:31]  fetched instruction.
- id_ready  out  1  instruction accepted this cycle (combinational).
- ex_stall  in  1  execute cannot take the ID/EX register.
- ex_flush  in  1  branch taken in execute; kills the ID/EX contents.
- id_valid  out  1  ID/EX holds a live instruction.
- id_rD, id_rA, id_rB  out  [0:REG_AW-1]  inst[6:10], [11:15], [16:20].
- id_ppp  out  [0:2]  inst[21:23].
- id_WW  out  [0:1]  inst[24:25].
- id_imm  out  [0:15]  inst[16:31].
- id_wrEn, id_memEn, id_memwrEn, id_bez, id_bnez, id_R_type  out  1 each  control strobes.
- id_illegal  out  1  decoded instruction is illegal (all strobes 0).
- id_hazard  out  1  the current if_inst is blocked by the scoreboard (combinational).

Behaviour:
- Opcode inst[0:5]: RTYPE 101010, VLD 100000, VSD 100001, VBEZ 100010, VBNEZ 100011, VNOP 111100. func = inst[26:31].
- Unary R-type funcs {000100, 000101, 001101, 010000, 010001, 010010}: require rB = 0, otherwise illegal.
- Other nonzero funcs are binary. func 000000 is illegal.
- Legal RTYPE: wrEn = 1, R_type = 1. Sources: rA; rB for binary funcs only.
- VLD: requires rA = 0, otherwise illegal. wrEn = 1, memEn = 1, no sources.
- VSD: requires rA = 0. memEn = 1, memwrEn = 1. Source: rD.
- VBEZ / VBNEZ: require rA = 0. Drive bez / bnez = 1. Source: rD.
- VNOP: all strobes 0, not illegal. Any other opcode is illegal.
- Scoreboard: cnt[r] per register, CNT_W bits.
  - Issue = id_valid && !ex_stall && !ex_flush.
  - On issue with id_wrEn and id_rD != 0, load cnt[id_rD] with ALU_LAT (R-type) or LD_LAT (VLD).
  - Otherwise decrement nonzero counters every cycle that ex_stall = 0; freeze them while ex_stall = 1.
- id_hazard = 1 if if_valid and any source register s != 0 satisfies either:
  - cnt[s] != 0, or
  - id_valid && id_wrEn && id_rD == s, the in-flight match that is not yet counted.
- adv = !id_valid || !ex_stall || ex_flush.
- id_ready = if_valid && adv && !id_hazard && !ex_flush.
- ID/EX register update priority:
  1. reset: id_valid = 0, every output field and strobe = 0, all cnt = 0.
  2. ex_flush: id_valid <= 0 and strobes <= 0. if_inst is not accepted. Scoreboard counters still decrement.
  3. !adv: hold all ID/EX contents.
  4. id_ready: load the decoded fields, id_valid <= 1.
  5. Otherwise, including a hazard: insert a bubble, id_valid <= 0 and strobes <= 0.
- Latency: decoded outputs appear 1 cycle after acceptance.
- Strobes are 0 whenever id_valid = 0. Illegal instructions are still accepted, with id_illegal = 1 and all strobes 0.
- Simultaneous ex_stall and ex_flush: flush wins.
- Reset mid-stall or mid-hazard clears everything. No pending writes survive reset.

Test Plan:
- Reset, then RTYPE func 000001 rD=3 rA=1 rB=2 with no stalls: one cycle later id_valid = 1, id_wrEn = 1, id_R_type = 1, id_rD = 3. cnt[3] becomes 2 on the next cycle.
- VLD rD=5, then binary R-type reading rA=5: consumer is held (id_hazard = 1, id_ready = 0) and bubbles fill ID/EX. Consumer issues exactly LD_LAT cycles after the load issued. Repeat with ALU_LAT for an R-type producer.
- Unary func 000100 with rB=7: id_illegal = 1, all strobes 0. Same func with rB=0: id_wrEn = 1. Also send VNOP and opcode 000000 and check each.
- VSD rA=0 rD=4 gives memEn = memwrEn = 1. VBEZ rA=1 gives bez = 0. VBNEZ rA=0 gives bnez = 1 and stalls while cnt[rD] != 0.
- Hold ex_stall = 1 for 3 cycles with id_valid = 1: outputs stable, id_ready = 0, counters frozen. Release: issue resumes with no lost or duplicated instruction.
- Assert ex_flush together with ex_stall while a VLD rD=6 sits in ID/EX: id_valid = 0 next cycle, cnt[6] stays 0, and a following reader of r6 issues without stall.
